// File: rtl/mbscore_int_sequencer.sv
// Interrupt sequencer: edge-pends, masks and prioritises request lines, then runs
// the halt/vector/jump handshake with the core, one interrupt in service at a time.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module mbscore_int_sequencer #(
   parameter int unsigned N_SRC      = 7,
   parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
   parameter int unsigned VEC_BASE   = 'h100,
   parameter int unsigned VEC_STRIDE = 'h10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_SRC-1:0]         int_src,
   input  logic [N_SRC-1:0]         int_mask,
   input  logic                     int_en_n,
   input  logic                     int_ack,
   input  logic                     int_eoi,
   output logic                     stop,
   output logic [ADDR_WIDTH-1:0]    int_addr,
   output logic [$clog2(N_SRC)-1:0] int_id,
   output logic                     int_jump,
   output logic                     in_service,
   output logic [N_SRC-1:0]         pending
);

   localparam int unsigned ID_W = $clog2(N_SRC);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t            state;
   logic [N_SRC-1:0]  src_d;
   logic [N_SRC-1:0]  rise;
   logic [N_SRC-1:0]  eligible;
   logic [N_SRC-1:0]  clr;
   logic [ID_W-1:0]   winner;
   logic [ADDR_WIDTH-1:0] vec_addr;

   // Rising edges, eligibility and lowest-index winner
   always_comb begin
      rise     = int_src & ~src_d;
      eligible = int_en_n ? '0 : (pending & ~int_mask);
      winner   = '0;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (eligible[i]) winner = ID_W'(i);
      end
      vec_addr = ADDR_WIDTH'(VEC_BASE + 32'(winner) * VEC_STRIDE);
      clr      = '0;
      if (state == REQ && int_ack) clr = N_SRC'(1) << int_id;
   end

   // Sequencer FSM; set beats clear on the pending register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         src_d      <= '0;
         pending    <= '0;
         stop       <= 1'b0;
         int_addr   <= '0;
         int_id     <= '0;
         int_jump   <= 1'b0;
         in_service <= 1'b0;
      end else begin
         src_d    <= int_src;
         pending  <= (pending & ~clr) | rise;
         int_jump <= 1'b0;
         case (state)
            IDLE: begin
               if (|eligible) begin
                  state    <= REQ;
                  int_id   <= winner;
                  int_addr <= vec_addr;
                  stop     <= 1'b1;
               end
            end
            REQ: begin
               if (int_ack) begin
                  state      <= SERVICE;
                  stop       <= 1'b0;
                  int_jump   <= 1'b1;
                  in_service <= 1'b1;
               end
            end
            SERVICE: begin
               if (int_eoi) begin
                  state      <= IDLE;
                  in_service <= 1'b0;
                  int_addr   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mbscore_int_sequencer.sv
// Bench for mbscore_int_sequencer: directed scenarios plus random traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_mbscore_int_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  int_src, int_mask;
   logic        int_en_n, int_ack, int_eoi;
   logic        stop, int_jump, in_service;
   logic [15:0] int_addr;
   logic [2:0]  int_id;
   logic [6:0]  pending;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [6:0]  m_pend, m_srcd;
   int          m_phase;      // 0 waiting, 1 offering vector, 2 handler running
   logic        m_stop, m_jump, m_insvc;
   logic [2:0]  m_id;
   logic [15:0] m_addr;

   mbscore_int_sequencer #(.N_SRC(7), .ADDR_WIDTH(16), .VEC_BASE('h100), .VEC_STRIDE('h10)) dut (
      .clk(clk), .rst(rst), .int_src(int_src), .int_mask(int_mask), .int_en_n(int_en_n),
      .int_ack(int_ack), .int_eoi(int_eoi), .stop(stop), .int_addr(int_addr), .int_id(int_id),
      .int_jump(int_jump), .in_service(in_service), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_srcd = '0; m_phase = 0;
      m_stop = 0; m_jump = 0; m_insvc = 0; m_id = '0; m_addr = '0;
   endtask

   function automatic logic [2:0] lowest(input logic [6:0] v);
      for (int i = 0; i < 7; i++) if (v[i]) return 3'(i);
      return 3'd0;
   endfunction

   // One clock of the interrupt protocol, evaluated from current inputs
   task automatic model_edge();
      logic [6:0] rise, elig, nxt;
      if (rst) begin model_reset(); return; end
      rise   = int_src & ~m_srcd;
      m_srcd = int_src;
      m_jump = 0;
      elig   = int_en_n ? 7'd0 : (m_pend & ~int_mask);
      nxt    = m_pend;
      if (m_phase == 0) begin
         if (elig != 0) begin
            m_id = lowest(elig); m_addr = 16'(256 + 16 * int'(m_id));
            m_stop = 1; m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (int_ack) begin
            nxt[m_id] = 1'b0;
            m_stop = 0; m_jump = 1; m_insvc = 1; m_phase = 2;
         end
      end else if (int_eoi) begin
         m_phase = 0; m_insvc = 0; m_addr = '0;
      end
      m_pend = nxt | rise;
   endtask

   task automatic cmp_model();
      chk("stop", 32'(stop), 32'(m_stop));
      chk("int_addr", 32'(int_addr), 32'(m_addr));
      chk("int_id", 32'(int_id), 32'(m_id));
      chk("int_jump", 32'(int_jump), 32'(m_jump));
      chk("in_service", 32'(in_service), 32'(m_insvc));
      chk("pending", 32'(pending), 32'(m_pend));
   endtask

   // Advance one clock, update model at the edge, compare just after it
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      cmp_model();
   endtask

   task automatic drive(input logic [6:0] s, input logic a, input logic e);
      int_src = s; int_ack = a; int_eoi = e;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_stop"}, 32'(stop), 0);
      chk({tag, "_addr"}, 32'(int_addr), 0);
      chk({tag, "_id"}, 32'(int_id), 0);
      chk({tag, "_jump"}, 32'(int_jump), 0);
      chk({tag, "_insvc"}, 32'(in_service), 0);
      chk({tag, "_pend"}, 32'(pending), 0);
   endtask

   // Assert reset between edges and confirm outputs clear before any clock
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1 check_zero(tag);
      model_reset();
      tick();
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; int_mask = '0; int_en_n = 1'b0;
      drive(7'h00, 0, 0);
      model_reset();
      #1 check_zero("reset");
      @(posedge clk); #1 rst = 1'b0;
      tick();

      // 1: single source, full handshake
      drive(7'h04, 0, 0); tick();
      chk("t1_pend", 32'(pending), 32'h04); chk("t1_nostop", 32'(stop), 0);
      tick();
      chk("t1_stop", 32'(stop), 1); chk("t1_id", 32'(int_id), 2); chk("t1_addr", 32'(int_addr), 32'h120);
      drive(7'h04, 1, 0); tick();
      chk("t1_jump", 32'(int_jump), 1); chk("t1_pclr", 32'(pending), 0); chk("t1_insvc", 32'(in_service), 1);
      drive(7'h00, 0, 0); tick();
      chk("t1_jump1cyc", 32'(int_jump), 0);
      drive(7'h00, 0, 1); tick();
      chk("t1_eoi", 32'(in_service), 0);
      drive(7'h00, 0, 0); tick();

      // 2: simultaneous arrival, lower index first
      drive(7'h21, 0, 0); tick(); tick();
      chk("t2_id0", 32'(int_id), 0); chk("t2_addr0", 32'(int_addr), 32'h100);
      drive(7'h00, 1, 0); tick();
      chk("t2_p5", 32'(pending), 32'h20);
      drive(7'h00, 0, 1); tick();
      chk("t2_idle_nostop", 32'(stop), 0);
      drive(7'h00, 0, 0); tick();
      chk("t2_stop5", 32'(stop), 1); chk("t2_id5", 32'(int_id), 5); chk("t2_addr5", 32'(int_addr), 32'h150);
      drive(7'h00, 1, 0); tick();
      drive(7'h00, 0, 1); tick();
      drive(7'h00, 0, 0); tick();

      // 3: masked source pends but is not selected until unmasked
      int_mask = 7'h02; drive(7'h02, 0, 0); tick(); tick(); tick();
      chk("t3_pend", 32'(pending), 32'h02); chk("t3_nostop", 32'(stop), 0);
      int_mask = 7'h00; tick(); tick();
      chk("t3_stop", 32'(stop), 1); chk("t3_id", 32'(int_id), 1);
      drive(7'h00, 1, 0); tick(); drive(7'h00, 0, 1); tick(); drive(7'h00, 0, 0); tick();

      // 4: global disable holds off selection
      int_en_n = 1'b1; drive(7'h08, 0, 0); tick(); tick(); tick();
      chk("t4_pend", 32'(pending), 32'h08); chk("t4_nostop", 32'(stop), 0);
      int_en_n = 1'b0; tick(); tick();
      chk("t4_id", 32'(int_id), 3); chk("t4_stop", 32'(stop), 1);
      drive(7'h00, 1, 0); tick(); drive(7'h00, 0, 1); tick(); drive(7'h00, 0, 0); tick();

      // 5: stray ack/eoi and re-edge on the ack cycle
      drive(7'h00, 1, 0); tick();
      chk("t5_stray_ack", 32'(int_jump), 0);
      drive(7'h10, 0, 0); tick();
      drive(7'h00, 0, 0); tick();
      chk("t5_req", 32'(int_id), 4);
      drive(7'h00, 0, 1); tick();
      chk("t5_stray_eoi", 32'(stop), 1);
      drive(7'h10, 1, 0); tick();
      chk("t5_setwins", 32'(pending), 32'h10); chk("t5_jump", 32'(int_jump), 1);
      drive(7'h10, 0, 1); tick();
      drive(7'h10, 0, 0); tick();
      chk("t5_reoffer", 32'(stop), 1); chk("t5_reid", 32'(int_id), 4);
      drive(7'h10, 1, 0); tick(); drive(7'h00, 0, 1); tick(); drive(7'h00, 0, 0); tick();

      // 6: reset mid-REQ and mid-SERVICE, line held high across reset
      drive(7'h40, 0, 0); tick(); tick();
      chk("t6_req", 32'(stop), 1);
      async_reset("t6_rst_req");
      tick();
      chk("t6_repend", 32'(pending), 32'h40);
      tick(); drive(7'h40, 1, 0); tick();
      chk("t6_svc", 32'(in_service), 1);
      drive(7'h40, 0, 0);
      async_reset("t6_rst_svc");
      tick(); tick();
      chk("t6_once", 32'(int_id), 6);
      drive(7'h40, 1, 0); tick();
      drive(7'h40, 0, 0); tick(); tick();
      chk("t6_no_repend", 32'(pending), 0);
      drive(7'h00, 0, 1); tick(); drive(7'h00, 0, 0); tick();

      // random traffic against the model
      for (int n = 0; n < 800; n++) begin
         int_src  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
         if ($urandom_range(0, 15) == 0) int_mask = 7'($urandom) & 7'($urandom);
         int_en_n = ($urandom_range(0, 9) == 0);
         int_ack  = ($urandom_range(0, 2) == 0);
         int_eoi  = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
